alu_operation_issuer: RTL and testbench

ALU_OPERATION_ISSUER -- requirements
Module: Alu_operation_issuer

---
 rtl/alu_operation_issuer.sv | 163 ++++++++++++++++
 tb/tb_alu_operation_issuer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operation_issuer.sv
// alu_operation_issuer: request/response sequencer for an external combinational ALU.
// A request is accepted in IDLE. A legal op (0x00-0x10) loads the ALU drive registers,
// spends one EXEC cycle while the ALU settles, then presents the captured result in RESP.
// An illegal op (>= 0x11) skips EXEC and answers at once with result 0, zero 1, err 01.
// Divide (0x06) with b == 0 reports err 10 but still returns whatever the ALU produced.
// The response is held stable in RESP until rsp_valid && rsp_ready, then the FSM returns to IDLE.
//
// Ports:
//   clk, rst_n                          clock, synchronous active-low reset
//   req_valid/req_ready                 request handshake (req_ready high only in IDLE)
//   req_op, req_a, req_b, req_shamt     request payload
//   rsp_valid/rsp_ready                 response handshake (rsp_valid high only in RESP)
//   rsp_result, rsp_zero, rsp_err       response payload (err: 00 ok, 01 illegal op, 10 div by zero)
//   alu_op, alu_data_1, alu_data_2,
//   alu_shamt                           registered ALU drive
//   alu_result, alu_zero                ALU outputs
//   issue_count                         completed responses (only with ALU_ISSUER_PERF_COUNT_EN)
//
// Optional feature macro: ALU_ISSUER_PERF_COUNT_EN adds the 32-bit issue_count output.
module alu_operation_issuer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OP_WIDTH-1:0]   req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [OP_WIDTH-1:0]   req_shamt,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_zero,
  output logic [1:0]            rsp_err,
  output logic [OP_WIDTH-1:0]   alu_op,
  output logic [DATA_WIDTH-1:0] alu_data_1,
  output logic [DATA_WIDTH-1:0] alu_data_2,
  output logic [OP_WIDTH-1:0]   alu_shamt,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero
`ifdef ALU_ISSUER_PERF_COUNT_EN
  ,
  output logic [31:0]           issue_count
`endif
);

  localparam logic [OP_WIDTH-1:0] OP_LAST_LEGAL = OP_WIDTH'(16);
  localparam logic [OP_WIDTH-1:0] OP_DIV        = OP_WIDTH'(6);
  localparam logic [1:0]          ERR_OK        = 2'b00;
  localparam logic [1:0]          ERR_ILLEGAL   = 2'b01;
  localparam logic [1:0]          ERR_DIV0      = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [OP_WIDTH-1:0]     alu_op_d;
  logic [DATA_WIDTH-1:0]   alu_data_1_d;
  logic [DATA_WIDTH-1:0]   alu_data_2_d;
  logic [OP_WIDTH-1:0]     alu_shamt_d;
  logic [DATA_WIDTH-1:0]   rsp_result_d;
  logic                    rsp_zero_d;
  logic [1:0]              rsp_err_d;
  logic                    accept_c;
  logic                    legal_c;
  logic                    rsp_done_c;

  // Next-state and next-register values; every register holds by default.
  always_comb begin
    state_d      = state_q;
    alu_op_d     = alu_op;
    alu_data_1_d = alu_data_1;
    alu_data_2_d = alu_data_2;
    alu_shamt_d  = alu_shamt;
    rsp_result_d = rsp_result;
    rsp_zero_d   = rsp_zero;
    rsp_err_d    = rsp_err;
    // req_ready is only ever high in IDLE, so it alone qualifies acceptance.
    accept_c     = req_valid && req_ready;
    legal_c      = (req_op <= OP_LAST_LEGAL);
    rsp_done_c   = rsp_valid && rsp_ready;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          if (legal_c) begin
            alu_op_d     = req_op;
            alu_data_1_d = req_a;
            alu_data_2_d = req_b;
            alu_shamt_d  = req_shamt;
            state_d      = EXEC;
          end else begin
            // ALU drive stays untouched so the ALU never sees the illegal op.
            rsp_result_d = '0;
            rsp_zero_d   = 1'b1;
            rsp_err_d    = ERR_ILLEGAL;
            state_d      = RESP;
          end
        end
      end
      EXEC: begin
        // Drive registers still hold the accepted payload, so div-by-zero is judged from them.
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_err_d    = ((alu_op == OP_DIV) && (alu_data_2 == '0)) ? ERR_DIV0 : ERR_OK;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_done_c) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; handshake flags follow the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= ERR_OK;
      alu_op     <= '0;
      alu_data_1 <= '0;
      alu_data_2 <= '0;
      alu_shamt  <= '0;
    end else begin
      state_q    <= state_d;
      req_ready  <= (state_d == IDLE);
      rsp_valid  <= (state_d == RESP);
      rsp_result <= rsp_result_d;
      rsp_zero   <= rsp_zero_d;
      rsp_err    <= rsp_err_d;
      alu_op     <= alu_op_d;
      alu_data_1 <= alu_data_1_d;
      alu_data_2 <= alu_data_2_d;
      alu_shamt  <= alu_shamt_d;
    end
  end

`ifdef ALU_ISSUER_PERF_COUNT_EN
  // Completed-response counter; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_count <= 32'd0;
    end else if (rsp_done_c) begin
      issue_count <= issue_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_operation_issuer.sv
// Testbench for alu_operation_issuer: table of vectors pushed to a scoreboard,
// a negedge monitor popping and comparing responses, plus stall and reset sequences.
module tb_alu_operation_issuer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_shamt;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic [1:0]  rsp_err;
  logic [4:0]  alu_op;
  logic [31:0] alu_data_1;
  logic [31:0] alu_data_2;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_result;
  logic        alu_zero;
`ifdef ALU_ISSUER_PERF_COUNT_EN
  logic [31:0] issue_count;
`endif

  alu_operation_issuer #(.DATA_WIDTH(32), .OP_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_data_1(alu_data_1), .alu_data_2(alu_data_2), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero)
`ifdef ALU_ISSUER_PERF_COUNT_EN
    , .issue_count(issue_count)
`endif
  );

  always #5 clk = ~clk;

  // Combinational ALU standing in for the real one; divide by zero passes a through.
  always_comb begin
    case (alu_op)
      5'h00:   alu_result = alu_data_1 + alu_data_2;
      5'h01:   alu_result = alu_data_1 - alu_data_2;
      5'h02:   alu_result = alu_data_1 & alu_data_2;
      5'h03:   alu_result = alu_data_1 | alu_data_2;
      5'h04:   alu_result = alu_data_1 ^ alu_data_2;
      5'h05:   alu_result = alu_data_1 << alu_shamt;
      5'h06:   alu_result = (alu_data_2 == 32'd0) ? alu_data_1 : alu_data_1 / alu_data_2;
      5'h07:   alu_result = alu_data_1 >> alu_shamt;
      default: alu_result = alu_data_1;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] res;
    logic        zero;
    logic [1:0]  err;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic [1:0]  err;
    logic [4:0]  aop;
    int          acc;
    int          lat;
  } exp_t;

  vec_t        tbl [12];
  exp_t        sb [$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          exp_cnt = 0;
  bit          seen = 1'b0;
  logic [4:0]  last_op = 5'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Response monitor: latency on first rsp_valid, payload on the handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (rsp_valid) begin
      if (sb.size() == 0) begin
        fail("unexpected_rsp");
      end else begin
        if (!seen) begin
          chk("latency", 64'(cyc + 1 - sb[0].acc), 64'(sb[0].lat));
          seen = 1'b1;
        end
        if (rsp_ready) begin
          chk("rsp_result", 64'(rsp_result), 64'(sb[0].res));
          chk("rsp_zero", 64'(rsp_zero), 64'(sb[0].zero));
          chk("rsp_err", 64'(rsp_err), 64'(sb[0].err));
          chk("alu_op_held", 64'(alu_op), 64'(sb[0].aop));
`ifdef ALU_ISSUER_PERF_COUNT_EN
          chk("issue_count", 64'(issue_count), 64'(exp_cnt));
          exp_cnt++;
`endif
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Drive one request, wait for acceptance, push expectation, check ALU drive.
  task automatic issue(input vec_t v);
    exp_t e;
    bit   legal;
    int   n;
    legal     = (v.op <= 5'h10);
    req_valid = 1'b1;
    req_op    = v.op;
    req_a     = v.a;
    req_b     = v.b;
    req_shamt = v.shamt;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      fail("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    if (legal) last_op = v.op;
    e.res  = v.res;
    e.zero = v.zero;
    e.err  = v.err;
    e.aop  = last_op;
    e.acc  = cyc + 1;
    e.lat  = legal ? 2 : 1;
    sb.push_back(e);
    @(posedge clk); #1;
    chk("alu_op", 64'(alu_op), 64'(last_op));
    if (legal) begin
      chk("alu_data_1", 64'(alu_data_1), 64'(v.a));
      chk("alu_data_2", 64'(alu_data_2), 64'(v.b));
    end
    // Scramble the payload; it must be ignored outside IDLE.
    req_valid = 1'b0;
    req_op    = 5'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    req_shamt = 5'($urandom);
  endtask

  task automatic drain(input bit rand_ready);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (sb.size() != 0) begin
      fail("drain_timeout");
      sb.delete();
    end
    rsp_ready = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{5'h00, 32'd5,          32'd7,     5'd0, 32'd12,     1'b0, 2'b00};
    tbl[1]  = '{5'h01, 32'd9,          32'd9,     5'd0, 32'd0,      1'b1, 2'b00};
    tbl[2]  = '{5'h06, 32'd40,         32'd0,     5'd0, 32'd40,     1'b0, 2'b10};
    tbl[3]  = '{5'h15, 32'd3,          32'd4,     5'd0, 32'd0,      1'b1, 2'b01};
    tbl[4]  = '{5'h02, 32'hF0,         32'h0F,    5'd0, 32'd0,      1'b1, 2'b00};
    tbl[5]  = '{5'h05, 32'd1,          32'd0,     5'd4, 32'd16,     1'b0, 2'b00};
    tbl[6]  = '{5'h06, 32'd100,        32'd7,     5'd0, 32'd14,     1'b0, 2'b00};
    tbl[7]  = '{5'h10, 32'h1234,       32'd3,     5'd0, 32'h1234,   1'b0, 2'b00};
    tbl[8]  = '{5'h11, 32'd8,          32'd8,     5'd0, 32'd0,      1'b1, 2'b01};
    tbl[9]  = '{5'h1F, 32'd1,          32'd1,     5'd0, 32'd0,      1'b1, 2'b01};
    tbl[10] = '{5'h03, 32'hA0,         32'h05,    5'd0, 32'hA5,     1'b0, 2'b00};
    tbl[11] = '{5'h00, 32'hFFFF_FFFF,  32'd1,     5'd0, 32'd0,      1'b1, 2'b00};

    rst_n = 1'b0; req_valid = 1'b0; req_op = 5'h0; req_a = 32'd0; req_b = 32'd0;
    req_shamt = 5'd0; rsp_ready = 1'b1;

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_alu_op", 64'(alu_op), 64'd0);
    chk("rst_rsp_result", 64'(rsp_result), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    // Table pass with ready held high, then with random backpressure.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 12; i++) begin
        issue(tbl[i]);
        drain(p == 1);
      end
    end

    // Response stall: payload and ALU drive hold, no new request taken.
    rsp_ready = 1'b0;
    issue('{5'h00, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0, 2'b00});
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      chk("stall_result", 64'(rsp_result), 64'd7);
      chk("stall_alu_data_1", 64'(alu_data_1), 64'd3);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post_hs_req_ready", 64'(req_ready), 64'd1);
    chk("stall_sb_empty", 64'(sb.size()), 64'd0);

    // Reset while in EXEC: response is discarded, outputs return to zero.
    issue('{5'h04, 32'h55, 32'hAA, 5'd0, 32'hFF, 1'b0, 2'b00});
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    chk("exec_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("exec_rst_req_ready", 64'(req_ready), 64'd0);
    chk("exec_rst_alu_op", 64'(alu_op), 64'd0);
    chk("exec_rst_alu_data_1", 64'(alu_data_1), 64'd0);
    chk("exec_rst_rsp_result", 64'(rsp_result), 64'd0);
    chk("exec_rst_rsp_err", 64'(rsp_err), 64'd0);
`ifdef ALU_ISSUER_PERF_COUNT_EN
    chk("exec_rst_issue_count", 64'(issue_count), 64'd0);
    exp_cnt = 0;
`endif
    last_op = 5'h00;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("after_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("after_rst_req_ready", 64'(req_ready), 64'd1);

    // Recovery: an illegal op first (ALU drive must stay at reset value), then a legal one.
    issue(tbl[8]);
    drain(1'b0);
    issue(tbl[0]);
    drain(1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
